// File: rtl/tx_pkg.sv
// Shared types and helpers for the Tx serializer: FSM state encoding,
// line idle level and width/length helpers.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned clk_div,
                                               input int unsigned stop_bits);
    return (1 + data_w + stop_bits) * clk_div;
  endfunction

  // Width of a counter holding 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and flags the last
// cycle of each bit period; held cleared while disabled.
module tx_baud_tick
  import tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = (CLK_DIV > 1) ? CW'(CLK_DIV - 2) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // pre_tick marks the cycle before a tick so the parent can register
  // outputs that must line up with the tick cycle itself
  always_comb begin
    tick     = enable && (cnt == LAST);
    pre_tick = enable && ((CLK_DIV == 1) || (cnt == PRE));
  end

endmodule

// File: rtl/tx_serializer.sv
// UART-style transmitter: accepts a parallel word over valid/ready and sends
// start bit, DATA_W data bits MSB-first and STOP_BITS stop bits.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] TxDinTmp,
  input  logic              TxValid,
  output logic              TxReady,
  output logic              TxOut,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [BIT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              tick;
  logic              pre_tick;
  logic              last_bit;
  logic              last_stop;
  logic              enter_last_stop;
  logic              done_next;

  tx_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state != IDLE),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // TxDone is registered, so it is raised one cycle ahead: either inside the
  // last stop bit, or (CLK_DIV=1) on the tick that enters the last stop bit
  always_comb begin
    shifted         = shreg << 1;
    last_bit        = (bit_cnt == LAST_BIT);
    last_stop       = (stop_cnt == 1'(STOP_BITS - 1));
    enter_last_stop = ((state == DATA) && last_bit && (STOP_BITS == 1)) ||
                      ((state == STOP) && (STOP_BITS == 2) && !stop_cnt);
    done_next       = pre_tick && (tick ? enter_last_stop
                                        : ((state == STOP) && last_stop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      TxOut    <= LINE_IDLE;
      TxReady  <= 1'b1;
      TxBusy   <= 1'b0;
      TxDone   <= 1'b0;
    end else begin
      TxDone <= done_next;
      case (state)
        IDLE: begin
          if (TxValid) begin
            shreg    <= TxDinTmp;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= START;
            TxOut    <= 1'b0;
            TxReady  <= 1'b0;
            TxBusy   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            TxOut <= shreg[DATA_W-1];
          end
        end
        DATA: begin
          if (tick) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (last_bit) begin
              state <= STOP;
              TxOut <= LINE_IDLE;
            end else begin
              shreg <= shifted;
              TxOut <= shifted[DATA_W-1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              state   <= IDLE;
              TxReady <= 1'b1;
              TxBusy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          shreg    <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          TxOut    <= LINE_IDLE;
          TxReady  <= 1'b1;
          TxBusy   <= 1'b0;
          TxDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: one instance at the default settings
// and one at CLK_DIV=1, STOP_BITS=2, each with a cycle-exact line monitor.
module tb_tx_serializer;

  localparam int W  = 32;
  localparam int C0 = 4;
  localparam int S0 = 1;
  localparam int C1 = 1;
  localparam int S1 = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0][W-1:0] din;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [1:0]       line;
  logic [1:0]       busy;
  logic [1:0]       done;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           in_frame [2];
  int           last_done_cyc [2];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_serializer #(.DATA_W(W), .CLK_DIV(C0), .STOP_BITS(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .TxDinTmp(din[0]), .TxValid(valid[0]),
    .TxReady(ready[0]), .TxOut(line[0]), .TxBusy(busy[0]), .TxDone(done[0])
  );

  tx_serializer #(.DATA_W(W), .CLK_DIV(C1), .STOP_BITS(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .TxDinTmp(din[1]), .TxValid(valid[1]),
    .TxReady(ready[1]), .TxOut(line[1]), .TxBusy(busy[1]), .TxDone(done[1])
  );

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic monitor(input int idx, input int c, input int s);
    int f, line_bad, ctl_bad, done_cnt, done_at;
    bit have_exp, aborted;
    logic [W-1:0] exp_w, got_w;
    logic exp_bit;
    f = (1 + W + s) * c;
    forever begin
      @(negedge clk);
      if (rst_n && !line[idx]) begin
        in_frame[idx] = 1'b1;
        have_exp = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
        exp_w = '0;
        if (have_exp) exp_w = (idx == 0) ? q0[0] : q1[0];
        got_w = '0; line_bad = 0; ctl_bad = 0; done_cnt = 0; done_at = -1;
        aborted = 1'b0;
        for (int t = 0; t <= f; t++) begin
          if (t > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (t == f) begin
            check($sformatf("dut%0d_ready_after_frame", idx), ready[idx], 1);
            check($sformatf("dut%0d_line_idle_after_frame", idx), line[idx], 1);
            check($sformatf("dut%0d_done_after_frame", idx), done[idx], 0);
          end else begin
            if (t < c) exp_bit = 1'b0;
            else if (t < (1 + W) * c) exp_bit = exp_w[W - t / c];
            else exp_bit = 1'b1;
            if (line[idx] !== exp_bit) line_bad++;
            if (busy[idx] !== 1'b1 || ready[idx] !== 1'b0) ctl_bad++;
            if (done[idx] === 1'b1) begin
              done_cnt++;
              done_at = t;
              last_done_cyc[idx] = cyc;
            end
            if (t >= c && t < (1 + W) * c && (t % c) == c / 2)
              got_w = {got_w[W-2:0], line[idx]};
          end
        end
        if (aborted) begin
          check($sformatf("dut%0d_abort_no_done", idx), done_cnt, 0);
        end else begin
          check($sformatf("dut%0d_frame_expected", idx), have_exp, 1);
          check($sformatf("dut%0d_line_bad_cycles", idx), line_bad, 0);
          check($sformatf("dut%0d_busy_ready_bad_cycles", idx), ctl_bad, 0);
          check($sformatf("dut%0d_done_count", idx), done_cnt, 1);
          check($sformatf("dut%0d_done_cycle", idx), done_at, f - 1);
          if (have_exp) begin
            if (idx == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            check($sformatf("dut%0d_data", idx), got_w, exp_w);
          end
        end
        in_frame[idx] = 1'b0;
      end
    end
  endtask

  task automatic send(input int idx, input logic [W-1:0] w, input bit push,
                      input bit hold, output int acc);
    din[idx]   = w;
    valid[idx] = 1'b1;
    for (int k = 0; k < 3000 && ready[idx] !== 1'b1; k++) @(negedge clk);
    check($sformatf("dut%0d_accept", idx), ready[idx], 1);
    acc = cyc;
    if (push) begin
      if (idx == 0) q0.push_back(w);
      else q1.push_back(w);
    end
    @(negedge clk);
    if (!hold) valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3000 &&
         (in_frame[idx] || ((idx == 0) ? q0.size() : q1.size()) != 0); k++)
      @(negedge clk);
    check($sformatf("dut%0d_wait_idle", idx), in_frame[idx], 0);
  endtask

  initial monitor(0, C0, S0);
  initial monitor(1, C1, S1);

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, bad;
    valid = '0;
    din   = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_rst_line", i), line[i], 1);
      check($sformatf("dut%0d_rst_ready", i), ready[i], 1);
      check($sformatf("dut%0d_rst_busy", i), busy[i], 0);
      check($sformatf("dut%0d_rst_done", i), done[i], 0);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (line !== 2'b11 || ready !== 2'b11 || busy !== 2'b00 || done !== 2'b00) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    send(0, 32'h0000_00FF, 1'b1, 1'b0, acc_a);
    wait_idle(0);

    send(0, 32'h0000_00FF, 1'b1, 1'b1, acc_a);
    send(0, 32'h0000_0011, 1'b1, 1'b0, acc_b);
    check("b2b_accept_after_done", acc_b - last_done_cyc[0], 1);
    wait_idle(0);

    send(0, 32'hA5A5_A5A5, 1'b1, 1'b0, acc_a);
    bad = 0;
    repeat (100) begin
      din[0]   = $urandom;
      valid[0] = 1'b1;
      @(negedge clk);
      if (ready[0] !== 1'b0) bad++;
    end
    valid[0] = 1'b0;
    check("ready_low_mid_frame", bad, 0);
    wait_idle(0);

    send(0, 32'hC3C3_0F0F, 1'b0, 1'b0, acc_a);
    repeat (45) @(negedge clk);
    check("busy_before_reset", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line", line[0], 1);
    check("midrst_busy", busy[0], 0);
    check("midrst_ready", ready[0], 1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0] !== 1'b0) bad++;
    end
    check("midrst_no_done", bad, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 32'h1234_5678, 1'b1, 1'b0, acc_a);
    wait_idle(0);

    send(1, 32'h8000_0001, 1'b1, 1'b0, acc_a);
    wait_idle(1);

    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Transmit stage directly downstream of the 32-bit Tx data-select mux.
- Consumes the selected parallel word (TxDinTmp) through a valid/ready handshake.
- Serializes each word onto a single line as a UART-style frame: start bit, DATA_W data bits MSB-first, STOP_BITS stop bits.
- The bit period is CLK_DIV clock cycles. The line idles high.

Parameters:
- DATA_W, 32, width of the parallel word and number of data bits per frame (>=1).
- CLK_DIV, 4, clock cycles per serial bit (>=1).
- STOP_BITS, 1, number of stop bits per frame (1 or 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- TxDinTmp  input  DATA_W  parallel word from the Tx data-select mux.
- TxValid  input  1  TxDinTmp holds a word to send.
- TxReady  output  1  block can accept a word this cycle.
- TxOut  output  1  serial line; idle = 1.
- TxBusy  output  1  frame in progress.
- TxDone  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately on rst_n low, including mid-frame: TxOut=1, TxReady=1, TxBusy=0, TxDone=0, shift register=0, counters=0, state=IDLE.
- All outputs are registered.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - TxReady=1, TxBusy=0, TxOut=1.
  - On the rising edge with TxValid && TxReady: latch TxDinTmp into the shift register, go to START.
  - Same edge: TxOut<=0, TxReady<=0, TxBusy<=1.
  - TxValid while TxReady=0 is ignored; upstream holds data, nothing is queued.
- START: TxOut=0 for CLK_DIV cycles, then DATA.
- DATA:
  - TxOut = shift register MSB. Each bit is held CLK_DIV cycles, then the register shifts left by 1.
  - After DATA_W bits, go to STOP. The bit counter is $clog2(DATA_W+1) bits wide.
- STOP:
  - TxOut=1 for STOP_BITS*CLK_DIV cycles.
  - TxDone=1 during the final cycle only.
  - Next edge: state=IDLE, TxReady=1, TxBusy=0.
- Frame length: (1+DATA_W+STOP_BITS)*CLK_DIV cycles, measured from the accept edge to the edge where TxReady returns to 1.
- Back-to-back: with TxValid held high, the next word is accepted on the first IDLE cycle. The idle gap on TxOut is exactly 1 cycle (TxOut=1).
- TxDinTmp changes during a frame have no effect; the word is captured at accept.
- CLK_DIV=1 is legal: one cycle per bit, no divider-counter wrap issues.
- The divider counter counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.
- Reset mid-frame aborts the frame. No TxDone is generated. TxOut=1 immediately, not waiting for the next clock edge.
- No invalid state is reachable. The default branch returns to IDLE with reset output values.

Decomposition:
- Package tx_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - Localparam helpers: frame length and counter widths via $clog2.
  - Line idle level constant (1'b1).
- One sub-module: tx_baud_tick.
  - Parameter CLK_DIV; inputs clk, rst_n, enable.
  - Output: one-cycle bit-boundary tick on the last cycle of each bit period.
  - Counter clears while enable=0.
- The top FSM uses the tick for all state and bit advances.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, TxValid=0 for 20 cycles -> TxOut=1, TxReady=1, TxBusy=0, TxDone=0 throughout.
- Single frame: DATA_W=32, CLK_DIV=4, word 32'h000000FF, 1-cycle TxValid pulse.
  - TxOut low for 4 cycles, then 24 bits of 0 (96 cycles), then 8 bits of 1 (32 cycles), then stop 1 for 4 cycles.
  - TxDone pulses at cycle 136. TxReady returns at cycle 136.
- Back-to-back: TxValid held high with words 32'h00FF then 32'h0011.
  - Second accept occurs exactly 1 cycle after the first frame's TxDone.
  - Decoded serial bits equal 0x000000FF then 0x00000011.
- Input stability: change TxDinTmp every cycle during a frame of 32'hA5A5A5A5 -> serial data still decodes 32'hA5A5A5A5. TxValid during the frame is not accepted (TxReady=0).
- Reset mid-frame: assert rst_n=0 in DATA at bit 10, off a clock edge.
  - TxOut=1 within the same cycle; no TxDone.
  - After release, a new word 32'h12345678 transmits correctly.
- Edge parameters: CLK_DIV=1, STOP_BITS=2, word 32'h80000001.
  - Frame is 35 cycles: first data bit 1, then thirty bits 0, last data bit 1, then two stop bits of 1.
